// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM word controller
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_SETUP,
    S_WR_STROBE,
    S_WR_HOLD,
    S_DONE
  } state_e;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  localparam int ROM_WIN_BITS = 16;

  function automatic logic [20:0] byte_addr(input logic [19:0] word, input logic sel);
    return {word, sel};
  endfunction

endpackage

// File: rtl/sram_cycle_timer.sv
// rtl/sram_cycle_timer.sv - loadable 4-bit down-counter; done while the count is zero
module sram_cycle_timer (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/sram_word_ctrl.sv
// rtl/sram_word_ctrl.sv - sequences 16-bit word requests into 8-bit async SRAM cycles
// Define SRAM_ROM_GUARD_EN to suppress writes into the ROM window while rom_wp=1.
module sram_word_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [20:0] ROM_BASE      = 21'h0F0000
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [20:0] addr,
  input  logic [1:0]  be,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  input  logic        rom_wp,
  output logic        rom_hit,
  output logic [20:0] sram_a,
  output logic [7:0]  sram_d_out,
  input  logic [7:0]  sram_d_in,
  output logic        sram_d_oe,
  output logic        sram_we_n
);

  localparam logic [3:0] TMR_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e      state_q;
  logic        ready_q, ack_q, rom_hit_q, oe_q, we_n_q, cur_q, be_hi_q;
  logic [19:0] word_q;
  logic [7:0]  hi_data_q, lo_byte_q, d_out_q;
  logic [15:0] rdata_q;
  logic [20:0] a_q;
  logic        tmr_load, tmr_done, rom_guard;

  logic unused_addr0;
  assign unused_addr0 = addr[0];

`ifdef SRAM_ROM_GUARD_EN
  assign rom_guard = we && rom_wp &&
                     (addr[20:ROM_WIN_BITS] == ROM_BASE[20:ROM_WIN_BITS]);
`else
  logic unused_rom_wp;
  assign unused_rom_wp = rom_wp;
  assign rom_guard     = 1'b0;
`endif

  // Reload on entry to each read byte and to each write strobe.
  assign tmr_load = (state_q == S_IDLE && req && !we) ||
                    (state_q == S_RD_LO && tmr_done) ||
                    (state_q == S_WR_SETUP);

  sram_cycle_timer u_timer (
    .clk_i      (clk_100),
    .reset_i    (reset),
    .load_i     (tmr_load),
    .load_val_i (TMR_LOAD),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      ack_q     <= 1'b0;
      rom_hit_q <= 1'b0;
      rdata_q   <= 16'd0;
      a_q       <= 21'd0;
      d_out_q   <= 8'd0;
      oe_q      <= 1'b0;
      we_n_q    <= 1'b1;
      word_q    <= 20'd0;
      be_hi_q   <= 1'b0;
      hi_data_q <= 8'd0;
      lo_byte_q <= 8'd0;
      cur_q     <= LO;
    end else begin
      ack_q     <= 1'b0;
      rom_hit_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req) begin
          ready_q   <= 1'b0;
          word_q    <= addr[20:1];
          be_hi_q   <= be[1];
          hi_data_q <= wdata[15:8];
          if (!we) begin
            state_q <= S_RD_LO;
            a_q     <= byte_addr(addr[20:1], LO);
          end else if (rom_guard || be == 2'b00) begin
            state_q   <= S_DONE;
            ack_q     <= 1'b1;
            rom_hit_q <= rom_guard;
          end else begin
            state_q <= S_WR_SETUP;
            cur_q   <= be[0] ? LO : HI;
            a_q     <= byte_addr(addr[20:1], be[0] ? LO : HI);
            d_out_q <= be[0] ? wdata[7:0] : wdata[15:8];
            oe_q    <= 1'b1;
          end
        end
        S_RD_LO: if (tmr_done) begin
          lo_byte_q <= sram_d_in;
          a_q       <= byte_addr(word_q, HI);
          state_q   <= S_RD_HI;
        end
        S_RD_HI: if (tmr_done) begin
          rdata_q <= {sram_d_in, lo_byte_q};
          ack_q   <= 1'b1;
          state_q <= S_DONE;
        end
        S_WR_SETUP: begin
          we_n_q  <= 1'b0;
          state_q <= S_WR_STROBE;
        end
        S_WR_STROBE: if (tmr_done) begin
          we_n_q  <= 1'b1;
          state_q <= S_WR_HOLD;
        end
        S_WR_HOLD: if (cur_q == LO && be_hi_q) begin
          cur_q   <= HI;
          a_q     <= byte_addr(word_q, HI);
          d_out_q <= hi_data_q;
          state_q <= S_WR_SETUP;
        end else begin
          oe_q    <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready      = ready_q;
  assign ack        = ack_q;
  assign rom_hit    = rom_hit_q;
  assign rdata      = rdata_q;
  assign sram_a     = a_q;
  assign sram_d_out = d_out_q;
  assign sram_d_oe  = oe_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb/tb_sram_word_ctrl.sv - randomized self-checking bench for sram_word_ctrl
module tb_sram_word_ctrl;

  localparam int AC = 2;
`ifdef SRAM_ROM_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk_100 = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0, rom_wp = 1'b0;
  logic [20:0] addr = 21'd0;
  logic [1:0]  be = 2'd0;
  logic [15:0] wdata = 16'd0;
  logic [7:0]  sram_d_in = 8'd0;
  logic        ready, ack, rom_hit, sram_d_oe, sram_we_n;
  logic [15:0] rdata;
  logic [20:0] sram_a;
  logic [7:0]  sram_d_out;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem     [logic [20:0]];
  logic [7:0] ref_mem [logic [20:0]];
  logic [15:0] exp_rd = 16'd0;

  int          strobe_q[$];
  int          low_len = 0;
  logic        prev_we_n = 1'b1;
  logic [20:0] prev_a = 21'd0;
  logic [7:0]  prev_d = 8'd0;

  always #5 clk_100 = ~clk_100;

  sram_word_ctrl #(.ACCESS_CYCLES(AC), .ROM_BASE(21'h0F0000)) dut (
    .clk_100    (clk_100),
    .reset      (reset),
    .req        (req),
    .ready      (ready),
    .we         (we),
    .addr       (addr),
    .be         (be),
    .wdata      (wdata),
    .rdata      (rdata),
    .ack        (ack),
    .rom_wp     (rom_wp),
    .rom_hit    (rom_hit),
    .sram_a     (sram_a),
    .sram_d_out (sram_d_out),
    .sram_d_in  (sram_d_in),
    .sram_d_oe  (sram_d_oe),
    .sram_we_n  (sram_we_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [20:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int exp_lat(input logic w, input logic [1:0] b, input logic guarded);
    if (!w) return 2 * AC + 1;
    if (guarded) return 1;
    return (int'(b[0]) + int'(b[1])) * (AC + 2) + 1;
  endfunction

  // Asynchronous SRAM: data latched on the rising edge of WE_n, read data settles by mid-cycle.
  always @(posedge sram_we_n) mem[sram_a] = sram_d_out;
  always @(negedge clk_100) sram_d_in = mem_rd(sram_a);

  always @(negedge clk_100) begin
    if (!sram_we_n) begin
      if (!prev_we_n) begin
        chk("a_stable_we_low", 32'(sram_a), 32'(prev_a));
        chk("d_stable_we_low", 32'(sram_d_out), 32'(prev_d));
      end
      low_len++;
    end else if (!prev_we_n) begin
      strobe_q.push_back(low_len);
      low_len = 0;
    end
    prev_we_n = sram_we_n;
    prev_a    = sram_a;
    prev_d    = sram_d_out;
  end

  task automatic txn_check(input logic w, input logic [20:0] a, input logic [1:0] b,
                           input logic [15:0] d);
    int          lat;
    int          n_bytes;
    logic [15:0] rd;
    logic        hit, guarded;
    logic [20:0] lo_a, hi_a;
    lo_a    = {a[20:1], 1'b0};
    hi_a    = {a[20:1], 1'b1};
    guarded = GUARD && w && rom_wp && (a[20:16] == 5'h0F);
    n_bytes = (w && !guarded) ? int'(b[0]) + int'(b[1]) : 0;
    @(negedge clk_100);
    strobe_q.delete();
    chk("ready_idle", 32'(ready), 32'd1);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(negedge clk_100);
    req = 1'b0; we = 1'($urandom); addr = 21'($urandom); be = 2'($urandom); wdata = 16'($urandom);
    chk("ready_busy", 32'(ready), 32'd0);
    lat = -1; rd = 16'd0; hit = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (ack) begin
        lat = n; rd = rdata; hit = rom_hit;
        break;
      end
      if (!w) chk("rd_no_drive", 32'({sram_we_n, sram_d_oe}), 32'd2);
      @(negedge clk_100);
    end
    chk("ack_cycle", 32'(lat), 32'(exp_lat(w, b, guarded)));
    chk("rom_hit", 32'(hit), 32'(guarded));
    if (!w) exp_rd = {ref_rd(hi_a), ref_rd(lo_a)};
    chk("rdata", 32'(rd), 32'(exp_rd));
    if (w && !guarded) begin
      if (b[0]) ref_mem[lo_a] = d[7:0];
      if (b[1]) ref_mem[hi_a] = d[15:8];
    end
    chk("n_strobes", 32'(strobe_q.size()), 32'(n_bytes));
    foreach (strobe_q[i]) chk("strobe_width", 32'(strobe_q[i]), 32'(AC));
    chk("mem_lo", 32'(mem_rd(lo_a)), 32'(ref_rd(lo_a)));
    chk("mem_hi", 32'(mem_rd(hi_a)), 32'(ref_rd(hi_a)));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int acks[$];
    int first_ready;
    mem[21'h012344] = 8'hA1;     mem[21'h012345] = 8'hB2;
    ref_mem[21'h012344] = 8'hA1; ref_mem[21'h012345] = 8'hB2;

    repeat (3) @(negedge clk_100);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rom_hit", 32'(rom_hit), 32'd0);
    chk("rst_sram_a", 32'(sram_a), 32'd0);
    chk("rst_d_out", 32'(sram_d_out), 32'd0);
    chk("rst_oe_we_n", 32'({sram_d_oe, sram_we_n}), 32'd1);
    reset = 1'b0;

    txn_check(1'b0, 21'h012345, 2'b00, 16'h0000);
    txn_check(1'b1, 21'h000100, 2'b11, 16'h55AA);
    txn_check(1'b0, 21'h000100, 2'b00, 16'h0000);
    txn_check(1'b1, 21'h000100, 2'b10, 16'h7700);
    txn_check(1'b1, 21'h000100, 2'b00, 16'hFFFF);
    txn_check(1'b0, 21'h000101, 2'b11, 16'h0000);

    rom_wp = 1'b1;
    txn_check(1'b1, 21'h0F8000, 2'b11, 16'hBEEF);
    txn_check(1'b0, 21'h0F8000, 2'b00, 16'h0000);
    rom_wp = 1'b0;
    txn_check(1'b1, 21'h0F8000, 2'b11, 16'hC0DE);
    txn_check(1'b0, 21'h0F8000, 2'b00, 16'h0000);

    // Reset during the first write strobe.
    @(negedge clk_100);
    req = 1'b1; we = 1'b1; addr = 21'h000200; be = 2'b11; wdata = 16'h1234;
    @(negedge clk_100);
    req = 1'b0;
    @(negedge clk_100);
    chk("rst_mid_strobe_low", 32'(sram_we_n), 32'd0);
    reset = 1'b1;
    @(negedge clk_100);
    chk("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_oe", 32'(sram_d_oe), 32'd0);
    reset = 1'b0;
    exp_rd = 16'd0;
    acks.delete();
    for (int n = 0; n < 12; n++) begin
      if (ack) acks.push_back(n);
      @(negedge clk_100);
    end
    chk("rst_mid_no_ack", 32'(acks.size()), 32'd0);
    txn_check(1'b0, 21'h012345, 2'b00, 16'h0000);

    // Back-to-back reads with req held high.
    @(negedge clk_100);
    req = 1'b1; we = 1'b0; addr = 21'h012344;
    acks.delete();
    first_ready = -1;
    for (int n = 1; n <= 2 * (2 * AC + 2) - 1; n++) begin
      @(negedge clk_100);
      if (ack) acks.push_back(n);
      if (ready && first_ready < 0) first_ready = n;
    end
    req = 1'b0;
    chk("b2b_n_acks", 32'(acks.size()), 32'd2);
    chk("b2b_ack1", 32'(acks.size() > 0 ? acks[0] : -1), 32'(2 * AC + 1));
    chk("b2b_ready", 32'(first_ready), 32'(2 * AC + 2));
    chk("b2b_ack2", 32'(acks.size() > 1 ? acks[1] : -1), 32'(2 * (2 * AC + 2) - 1));
    chk("b2b_rdata", 32'(rdata), 32'h0000B2A1);
    exp_rd = 16'hB2A1;

    for (int i = 0; i < 30; i++) begin
      logic [20:0] a;
      a = ($urandom_range(0, 3) == 0) ? 21'h0F8000 + 21'($urandom_range(0, 7))
                                      : 21'h001000 + 21'($urandom_range(0, 31));
      rom_wp = 1'($urandom);
      txn_check(1'($urandom), a, 2'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_word_ctrl.md
Name: sram_word_ctrl

Overview:
Controller between the PCXT chipset memory port and the board's external 2 MB x 8 asynchronous SRAM. Accepts 16-bit word requests with byte enables and splits each into sequenced 8-bit SRAM accesses. Generates the address, write-strobe and data-direction signals with programmable access timing. Outputs drive the SRAM pins directly; the tristate buffer sits at the top level.

Parameters:
ACCESS_CYCLES, 2, clk_100 cycles per byte read, and per write-strobe low width (legal 1..15)
ROM_BASE, 21'h0F0000, base of the 64 KB write-guarded window; only bits [20:16] are compared

Ports:
clk_100  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
req  in  1  request valid; sampled only while ready=1
ready  out  1  high in IDLE only
we  in  1  1=write, 0=read; sampled with req
addr  in  21  byte address; bit 0 ignored (word-aligned)
be  in  2  byte enables for writes [0]=low byte, [1]=high byte; ignored on reads
wdata  in  16  write data; sampled with req
rdata  out  16  read data; valid while ack=1; holds until next read completes
ack  out  1  one-cycle completion pulse
rom_wp  in  1  1=write-protect the ROM window (effective only with the optional feature)
rom_hit  out  1  one-cycle pulse when a write is suppressed by the guard
sram_a  out  21  SRAM address
sram_d_out  out  8  SRAM write data
sram_d_in  in  8  SRAM read data
sram_d_oe  out  1  1=drive the SRAM data bus
sram_we_n  out  1  SRAM write enable, active low

Behaviour:
- Clocking: one clock, clk_100; reset is synchronous and active-high. All outputs are registered.
- Reset values: ready=1, ack=0, rdata=0, rom_hit=0, sram_a=0, sram_d_out=0, sram_d_oe=0, sram_we_n=1. State is IDLE.
- Reset mid-operation: the FSM returns to IDLE at the next edge and sram_we_n is forced to 1. The in-flight request is dropped and no ack is issued.
- Acceptance: the cycle where req && ready is cycle 0. The controller latches we, addr, be and wdata. ready falls in cycle 1.
- Byte addresses: low byte uses {addr[20:1],1'b0}; high byte uses {addr[20:1],1'b1}. The low byte is always sequenced first.
- States: IDLE, RD_LO, RD_HI, WR_SETUP, WR_STROBE, WR_HOLD, DONE.
- Read sequence:
  - RD_LO lasts ACCESS_CYCLES cycles; sram_d_in is captured into rdata[7:0] on its last cycle.
  - RD_HI then runs the same way and captures rdata[15:8].
  - DONE follows: ack=1 for that cycle.
  - With ACCESS_CYCLES=2, ack is asserted in cycle 5.
  - sram_d_oe=0 and sram_we_n=1 throughout.
- Write sequence, per enabled byte:
  - WR_SETUP, 1 cycle: address and data valid, sram_d_oe=1, sram_we_n=1.
  - WR_STROBE, ACCESS_CYCLES cycles: sram_we_n=0.
  - WR_HOLD, 1 cycle: sram_we_n=1, data still driven.
  - Then the next enabled byte, or DONE.
  - Disabled bytes are skipped entirely.
- Write timing with ACCESS_CYCLES=2: be=11 gives ack in cycle 9; a single enabled byte gives ack in cycle 5.
- Write with be=00: no SRAM activity; DONE in cycle 1.
- sram_a and sram_d_out change only in WR_SETUP or at read-byte start, never while sram_we_n=0.
- sram_d_oe falls in the cycle after WR_HOLD, or is already 0 on entering DONE.
- DONE lasts one cycle and then returns to IDLE. ready is 0 during DONE, so back-to-back requests are spaced by at least one IDLE cycle.
- Timing counter: 4-bit down-counter, loaded with ACCESS_CYCLES-1 on entering RD_* or WR_STROBE.
- rdata: unchanged by writes.

Optional Feature:
Macro: SRAM_ROM_GUARD_EN.
- Defined: a write with addr[20:16]==ROM_BASE[20:16] while rom_wp=1 performs no SRAM cycle. The controller goes directly to DONE (ack in cycle 1) and pulses rom_hit together with ack. Reads are unaffected.
- Undefined: no comparison logic is built, rom_hit is tied 0, rom_wp is ignored, and all writes proceed.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum (7 states)
  - byte-select constants LO=0, HI=1
  - ROM window width constant (16)
- One natural sub-module, sram_cycle_timer: the loadable down-counter with a done flag, reused across the read and strobe phases. Everything else stays in one FSM module.

Test Plan:
- Read, ACCESS_CYCLES=2, addr=21'h012345, SRAM model holds 8'hA1 at 21'h012344 and 8'hB2 at 21'h012345 -> ack in cycle 5, rdata=16'hB2A1, sram_we_n stays 1.
- Write, be=11, addr=21'h000100, wdata=16'h55AA -> two WE_n low pulses of 2 cycles each; SRAM 21'h000100=8'hAA, 21'h000101=8'h55; ack in cycle 9.
- Write, be=10, wdata=16'h7700 -> only 21'h...1 written with 8'h77; ack in cycle 5; be=00 -> ack in cycle 1 with no strobe.
- Assert reset during WR_STROBE -> sram_we_n=1 after the next edge, no ack, ready=1; a following read succeeds.
- SRAM_ROM_GUARD_EN defined, rom_wp=1, write to 21'h0F8000 -> no strobe, ack and rom_hit in cycle 1, memory unchanged; same with rom_wp=0 -> write occurs.
- Back-to-back: req held high continuously -> second acceptance occurs exactly one cycle after the first ack; timing assertion checks that sram_a and sram_d_out never change while sram_we_n=0.
